stopwatch_ctrl: RTL

//  Control sequencer for the 8-digit stopwatch datapath behind top (seg/select scan display).

---
 rtl/stopwatch_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounces three raw buttons, classifies presses and
// runs the IDLE/RUN/PAUSE/LAP machine that strobes the time counter and display.
module stopwatch_ctrl #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic [2:0] button_in,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_latch,
  output logic       disp_freeze,
  output logic       disp_mode,
  output logic [1:0] state
);

  localparam int DB_CYC   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYC = CLK_FREQ / 1000 * LONG_MS;
  localparam int DB_W     = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int HOLD_W   = $clog2(LONG_CYC + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  // Hold count saturates at LONG_CYC; reaching the top doubles as "long already fired".
  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_MAX) ? v : v + 1'b1;
  endfunction

  logic [2:0]      sync_p0, sync_p1;
  logic            vld_p0, vld_p1;
  logic [DB_W-1:0] db_cnt [3];
  logic [2:0]      stable, stable_d, armed;
  logic [HOLD_W-1:0] hold_cnt;

  logic   p0, p1, btn2_fall, long_ev, short_ev;
  state_t state_q, state_nxt;
  logic   clr_nxt, lap_nxt, mode_nxt;

  // Stage p0/p1: two-flop synchronizer; vld marks when sync_p1 carries real input.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      sync_p0 <= button_in;
      sync_p1 <= sync_p0;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
    end
  end

  // Debounce and arming: a bit only arms once it is seen genuinely released.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      stable   <= '0;
      stable_d <= '0;
      armed    <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          stable[i] <= sync_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
        armed[i] <= armed[i] | (vld_p1 & ~sync_p1[i] & ~stable[i]);
      end
      stable_d <= stable;
    end
  end

  assign p0        = armed[0] & stable[0] & ~stable_d[0];
  assign p1        = armed[1] & stable[1] & ~stable_d[1];
  assign btn2_fall = armed[2] & ~stable[2] & stable_d[2];
  assign long_ev   = armed[2] & stable[2] & (hold_cnt == HOLD_LONG);
  assign short_ev  = btn2_fall & (hold_cnt != HOLD_MAX);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_cnt <= '0;
    end else if (armed[2] & stable[2]) begin
      hold_cnt <= sat_inc(hold_cnt);
    end else begin
      hold_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state_q;
    clr_nxt   = 1'b0;
    lap_nxt   = 1'b0;
    mode_nxt  = disp_mode ^ short_ev;
    if (long_ev) begin
      state_nxt = IDLE;
      clr_nxt   = 1'b1;
    end else if (p0) begin
      case (state_q)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        LAP:     state_nxt = PAUSE;
        default: state_nxt = IDLE;
      endcase
    end else if (p1) begin
      case (state_q)
        RUN, LAP: begin
          state_nxt = LAP;
          lap_nxt   = 1'b1;
        end
        PAUSE: begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
        end
        default: state_nxt = state_q;
      endcase
    end
  end

  // Stage out: state and Moore outputs registered together from the next state.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_en      <= 1'b0;
      cnt_clr     <= 1'b0;
      lap_latch   <= 1'b0;
      disp_freeze <= 1'b0;
      disp_mode   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_en      <= (state_nxt == RUN) || (state_nxt == LAP);
      cnt_clr     <= clr_nxt;
      lap_latch   <= lap_nxt;
      disp_freeze <= (state_nxt == LAP);
      disp_mode   <= mode_nxt;
    end
  end

  assign state = state_q;

endmodule
